// File: rtl/noc_axi_traffic_gen_if.sv
// AXI4 master-side bundle for the NoC traffic generator: AW, W, B, AR and R channels.
// The master modport is driven by the generator; the slave modport by the NoC ingress (NMU).
interface noc_axi_traffic_gen_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 128
);
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_awvalid;
  logic                m_axi_awready;

  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready;

  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;

  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [7:0]          m_axi_arlen;
  logic [2:0]          m_axi_arsize;
  logic [1:0]          m_axi_arburst;
  logic                m_axi_arvalid;
  logic                m_axi_arready;

  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;
  logic                m_axi_rlast;
  logic                m_axi_rvalid;
  logic                m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/noc_axi_traffic_gen.sv
// AXI4 traffic generator: writes NUM_BURSTS patterned INCR bursts, reads them back and checks.
// Optional NOC_GEN_LOOP_EN: restart automatically after DONE with an incremented seed.
module noc_axi_traffic_gen #(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       WIDTH      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       NUM_BURSTS = 16,
  parameter int unsigned       BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  noc_axi_traffic_gen_if.master axi,
  output logic [WIDTH-1:0]      out
);

  localparam int unsigned       Bytes      = DATA_W / 8;
  localparam int unsigned       Lanes      = DATA_W / 32;
  localparam int unsigned       CntW       = WIDTH - 2;
  localparam logic [ADDR_W-1:0] BurstBytes = ADDR_W'(BURST_LEN * Bytes);
  localparam logic [7:0]        LastBeat   = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LastBurst  = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    StIdle, StWrAw, StWrData, StWrResp, StRdAr, StRdData, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic [27:0]       k_q, k_d;       // global beat index within the current phase
  logic [27:0]       seed_q, seed_d;
  logic              fail_q, fail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [27:0]       beat_val;
  logic [DATA_W-1:0] pattern;
  logic [ADDR_W-1:0] burst_addr;
  logic              last_beat;
  logic              start_pass;
  logic              clear_status;

  assign beat_val   = k_q + seed_q;
  assign burst_addr = BASE_ADDR + ADDR_W'(burst_q) * BurstBytes;
  assign last_beat  = (beat_q == LastBeat);

  always_comb begin
    pattern = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      pattern[i*32 +: 32] = {beat_val, 4'(i)};
    end
  end

  // All outputs come from registers only; no ready input reaches a valid.
  assign axi.m_axi_awaddr  = burst_addr;
  assign axi.m_axi_awlen   = LastBeat;
  assign axi.m_axi_awsize  = 3'($clog2(Bytes));
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awvalid = (state_q == StWrAw);
  assign axi.m_axi_wdata   = pattern;
  assign axi.m_axi_wstrb   = '1;
  assign axi.m_axi_wlast   = last_beat;
  assign axi.m_axi_wvalid  = (state_q == StWrData);
  assign axi.m_axi_bready  = (state_q == StWrResp);
  assign axi.m_axi_araddr  = burst_addr;
  assign axi.m_axi_arlen   = LastBeat;
  assign axi.m_axi_arsize  = 3'($clog2(Bytes));
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arvalid = (state_q == StRdAr);
  assign axi.m_axi_rready  = (state_q == StRdData);
  assign out               = {state_q == StDone, fail_q, count_q};

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    k_d          = k_q;
    seed_d       = seed_q;
    fail_d       = fail_q;
    count_d      = count_q;
    start_pass   = 1'b0;
    clear_status = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_pass   = 1'b1;
          clear_status = 1'b1;
        end
      end
      StWrAw: begin
        if (axi.m_axi_awready) state_d = StWrData;
      end
      StWrData: begin
        if (axi.m_axi_wready) begin
          k_d = k_q + 28'd1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = StWrResp;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StWrResp: begin
        if (axi.m_axi_bvalid) begin
          if (axi.m_axi_bresp != 2'b00) fail_d = 1'b1;
          if (burst_q == LastBurst) begin
            burst_d = '0;
            k_d     = '0;
            state_d = StRdAr;
          end else begin
            burst_d = burst_q + 16'd1;
            state_d = StWrAw;
          end
        end
      end
      StRdAr: begin
        if (axi.m_axi_arready) state_d = StRdData;
      end
      StRdData: begin
        if (axi.m_axi_rvalid) begin
          if (!(&count_q)) count_d = count_q + 1'b1;
          if (axi.m_axi_rresp != 2'b00 || axi.m_axi_rdata != pattern ||
              axi.m_axi_rlast != last_beat) begin
            fail_d = 1'b1;
          end
          k_d = k_q + 28'd1;
          if (last_beat) begin
            beat_d = '0;
            if (burst_q == LastBurst) begin
              state_d = StDone;
            end else begin
              burst_d = burst_q + 16'd1;
              state_d = StRdAr;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StDone: begin
`ifdef NOC_GEN_LOOP_EN
        start_pass = 1'b1;
        seed_d     = seed_q + 28'd1;
`else
        if (start) begin
          start_pass   = 1'b1;
          clear_status = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (start_pass) begin
      state_d = StWrAw;
      burst_d = '0;
      beat_d  = '0;
      k_d     = '0;
    end
    if (clear_status) begin
      fail_d  = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      burst_q <= '0;
      beat_q  <= '0;
      k_q     <= '0;
      seed_q  <= '0;
      fail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      k_q     <= k_d;
      seed_q  <= seed_d;
      fail_q  <= fail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_noc_axi_traffic_gen.sv
// Bench for noc_axi_traffic_gen: memory slave with optional gaps and fault injection, plus a
// transaction-level model of addresses, beat patterns and the status word checked every cycle.
module tb_noc_axi_traffic_gen;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 128;
  localparam int WIDTH  = 32;
  localparam int NUM    = 16;
  localparam int LEN    = 4;
  localparam int TOTAL  = NUM * LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [WIDTH-1:0] status;

  noc_axi_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  noc_axi_traffic_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .WIDTH     (WIDTH),
    .BASE_ADDR (64'h0),
    .NUM_BURSTS(NUM),
    .BURST_LEN (LEN)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .axi  (axi),
    .out  (status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fault knobs
  bit gaps_en = 0;
  int corrupt_k = -1;
  int slverr_b = -1;
  int early_b = -1;
  bit start_ok = 0;

  // Model and slave state
  logic [127:0] mem [longint];
  logic [31:0]  seed_m;
  bit           exp_fail, exp_done;
  int           exp_count;
  int           aw_n, w_k, ar_n, r_k, wbeat, rbeat, b_burst, r_burst;
  int           aw_gap, w_gap, b_gap, ar_gap, r_gap;
  logic [63:0]  waddr, raddr, aw_hold, ar_hold;
  logic [127:0] w_hold;
  bit           aw_stall, w_stall, ar_stall, b_pend, b_fire, r_pend, r_fire;

  function automatic logic [127:0] pattern(input int k);
    logic [31:0]  v;
    logic [127:0] p;
    v = 32'(k) + seed_m;
    for (int i = 0; i < 4; i++) p[i*32 +: 32] = {v[27:0], 4'(i)};
    return p;
  endfunction

  function automatic int gap();
    return gaps_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  task automatic new_pass();
    aw_n = 0; w_k = 0; ar_n = 0; r_k = 0; wbeat = 0; rbeat = 0;
  endtask

  task automatic reset_slave();
    new_pass();
    exp_fail = 0; exp_done = 0; exp_count = 0; seed_m = '0;
    aw_stall = 0; w_stall = 0; ar_stall = 0;
    b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
    aw_gap = 0; w_gap = 0; b_gap = 0; ar_gap = 0; r_gap = 0;
    axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_arready = 0;
    axi.m_axi_bvalid = 0; axi.m_axi_bresp = 0;
    axi.m_axi_rvalid = 0; axi.m_axi_rresp = 0; axi.m_axi_rlast = 0; axi.m_axi_rdata = '0;
  endtask

  // Slave + model: every decision is taken on the falling edge for the next rising edge.
  initial begin
    reset_slave();
    forever begin
      @(negedge clk);
      if (rst) begin
        reset_slave();
      end else begin
        check("status", status, {exp_done, exp_fail, 30'(exp_count)});
`ifdef NOC_GEN_LOOP_EN
        if (exp_done) begin
          exp_done = 0;
          seed_m++;
          new_pass();
        end
`endif
        // B
        if (b_fire) begin axi.m_axi_bvalid = 0; b_fire = 0; end
        if (b_pend && !axi.m_axi_bvalid) begin
          if (b_gap > 0) b_gap--;
          else begin
            axi.m_axi_bvalid = 1;
            axi.m_axi_bresp = (b_burst == slverr_b) ? 2'b10 : 2'b00;
          end
        end
        if (axi.m_axi_bvalid && axi.m_axi_bready) begin
          b_fire = 1; b_pend = 0;
          if (axi.m_axi_bresp != 2'b00) exp_fail = 1;
        end
        // R
        if (r_fire) begin
          axi.m_axi_rvalid = 0; r_fire = 0; rbeat++; r_k++;
          if (rbeat == LEN) r_pend = 0;
        end
        if (r_pend && !axi.m_axi_rvalid) begin
          if (r_gap > 0) r_gap--;
          else begin
            axi.m_axi_rvalid = 1;
            axi.m_axi_rdata = mem[longint'(raddr >> 4) + longint'(rbeat)];
            if (r_k == corrupt_k) axi.m_axi_rdata[0] = ~axi.m_axi_rdata[0];
            axi.m_axi_rresp = 2'b00;
            axi.m_axi_rlast = (r_burst == early_b) ? (rbeat == 1) : (rbeat == LEN - 1);
            r_gap = gap();
          end
        end
        if (axi.m_axi_rvalid && axi.m_axi_rready) begin
          r_fire = 1;
          if (exp_count < 30'h3fffffff) exp_count++;
          if (axi.m_axi_rresp != 2'b00 || axi.m_axi_rdata !== pattern(r_k) ||
              axi.m_axi_rlast != (rbeat == LEN - 1)) exp_fail = 1;
          if (r_k == TOTAL - 1) exp_done = 1;
        end
        // AW
        if (aw_stall) begin
          check("awvalid_held", axi.m_axi_awvalid, 1'b1);
          check("awaddr_stable", axi.m_axi_awaddr, aw_hold);
        end
        aw_stall = 0;
        axi.m_axi_awready = 0;
        if (axi.m_axi_awvalid) begin
          if (aw_gap > 0) begin
            aw_gap--; aw_stall = 1; aw_hold = axi.m_axi_awaddr;
          end else begin
            axi.m_axi_awready = 1;
            check("awaddr", axi.m_axi_awaddr, 64'(aw_n) * 64);
            check("aw_len_size_burst", {axi.m_axi_awlen, axi.m_axi_awsize, axi.m_axi_awburst},
                  {8'd3, 3'd4, 2'b01});
            if (aw_n == 0) check("aw0_addr", axi.m_axi_awaddr, 64'h0);
            if (aw_n == 1) check("aw1_addr", axi.m_axi_awaddr, 64'h40);
            waddr = axi.m_axi_awaddr; wbeat = 0; b_burst = aw_n; aw_n++; aw_gap = gap();
          end
        end
        // W
        if (w_stall) begin
          check("wvalid_held", axi.m_axi_wvalid, 1'b1);
          check("wdata_stable", axi.m_axi_wdata, w_hold);
        end
        w_stall = 0;
        axi.m_axi_wready = 0;
        if (axi.m_axi_wvalid) begin
          if (w_gap > 0) begin
            w_gap--; w_stall = 1; w_hold = axi.m_axi_wdata;
          end else begin
            axi.m_axi_wready = 1;
            check("wdata", axi.m_axi_wdata, pattern(w_k));
            check("wstrb_wlast", {axi.m_axi_wstrb, axi.m_axi_wlast},
                  {16'hffff, 1'(wbeat == LEN - 1)});
            if (w_k == 0 && seed_m == 0) check("beat0_lane1", axi.m_axi_wdata[63:32], 32'h1);
            if (w_k == 0 && seed_m == 1) check("pass2_lane0", axi.m_axi_wdata[31:0], 32'h10);
            mem[longint'(waddr >> 4) + longint'(wbeat)] = axi.m_axi_wdata;
            wbeat++; w_k++; w_gap = gap();
            if (wbeat == LEN) begin b_pend = 1; b_gap = gap(); end
          end
        end
        // AR
        if (ar_stall) begin
          check("arvalid_held", axi.m_axi_arvalid, 1'b1);
          check("araddr_stable", axi.m_axi_araddr, ar_hold);
        end
        ar_stall = 0;
        axi.m_axi_arready = 0;
        if (axi.m_axi_arvalid) begin
          if (ar_gap > 0) begin
            ar_gap--; ar_stall = 1; ar_hold = axi.m_axi_araddr;
          end else begin
            axi.m_axi_arready = 1;
            check("araddr", axi.m_axi_araddr, 64'(ar_n) * 64);
            check("ar_len_size_burst", {axi.m_axi_arlen, axi.m_axi_arsize, axi.m_axi_arburst},
                  {8'd3, 3'd4, 2'b01});
            raddr = axi.m_axi_araddr; rbeat = 0; r_burst = ar_n; r_pend = 1;
            ar_n++; ar_gap = gap(); r_gap = gap();
          end
        end
        if (start && start_ok) begin
          new_pass();
          exp_fail = 0; exp_count = 0; exp_done = 0;
        end
      end
    end
  end

  task automatic pulse_start(input bit ok);
    @(posedge clk); #1;
    start_ok = ok; start = 1;
    @(posedge clk); #1;
    start = 0; start_ok = 0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_status);
    int n;
    n = 0;
    while (!exp_done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!exp_done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got status %h expected done within budget", name, status);
    end else begin
      check(name, status, exp_status);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("reset_status", status, 32'h0);
    check("reset_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                           axi.m_axi_bready, axi.m_axi_rready}, 5'b0);
`ifdef NOC_GEN_LOOP_EN
    pulse_start(1);
    wait_done("loop_pass1", 32'h8000_0040);
    @(posedge clk); #1;
    wait_done("loop_pass2", 32'h8000_0080);
`else
    pulse_start(1);
    wait_done("zero_wait", 32'h8000_0040);
    repeat (5) @(posedge clk);
    #1 check("done_hold", status, 32'h8000_0040);

    gaps_en = 1;
    pulse_start(1);
    wait_done("gaps", 32'h8000_0040);
    gaps_en = 0;

    corrupt_k = 10;
    pulse_start(1);
    wait_done("corrupt_beat10", 32'hC000_0040);
    corrupt_k = -1;

    slverr_b = 3;
    pulse_start(1);
    wait_done("slverr_burst3", 32'hC000_0040);
    slverr_b = -1;

    early_b = 5;
    pulse_start(1);
    wait_done("early_rlast", 32'hC000_0040);
    early_b = -1;

    // Reset while a write burst is in flight
    pulse_start(1);
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (!axi.m_axi_wvalid && n < 200) begin @(posedge clk); #1; n++; end
    check("wvalid_before_rst", axi.m_axi_wvalid, 1'b1);
    rst = 1;
    #1;
    check("rst_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                         axi.m_axi_bready, axi.m_axi_rready}, 5'b0);
    check("rst_status", status, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    pulse_start(1);
    wait_done("after_reset", 32'h8000_0040);

    // start during RD_DATA must be ignored
    pulse_start(1);
    n = 0;
    while (!axi.m_axi_rready && n < 2000) begin @(posedge clk); #1; n++; end
    check("rready_seen", axi.m_axi_rready, 1'b1);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done("start_ignored", 32'h8000_0040);
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_axi_traffic_gen.md
Name: noc_axi_traffic_gen

Overview:
- AXI4 memory-mapped master that drives traffic into the NoC ingress (NMU) port of the simulation top and produces the status word on `out`.
- Writes NUM_BURSTS incrementing-pattern INCR bursts starting at BASE_ADDR, reads them all back, compares every beat and reports done/fail/beat count.
- Sits directly upstream of the NoC and downstream of nothing except clk/rst/start.

Parameters:
- ADDR_W, 64, AXI address width.
- DATA_W, 128, AXI data width; multiple of 32, 32..512.
- WIDTH, 32, status output width; >= 8.
- BASE_ADDR, 64'h0, first address; 4 KB aligned.
- NUM_BURSTS, 16, bursts per phase; 1..65535.
- BURST_LEN, 4, beats per burst; 1..256; BURST_LEN*DATA_W/8 divides 4096.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a pass from IDLE or DONE
- m_axi_aw{addr,len,size,burst,valid}  out  ADDR_W/8/3/2/1  write address channel
- m_axi_awready  in  1
- m_axi_w{data,strb,last,valid}  out  DATA_W/DATA_W/8/1/1  write data channel
- m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- m_axi_ar{addr,len,size,burst,valid}  out  ADDR_W/8/3/2/1  read address channel
- m_axi_arready  in  1
- m_axi_r{data,resp,last,valid}  in  DATA_W/2/1/1;  m_axi_rready  out  1
- out  out  WIDTH  [WIDTH-1]=done, [WIDTH-2]=fail, [WIDTH-3:0]=read beats checked (saturating)

Behaviour:
- Clock is `clk`; reset is `rst`, asynchronous, active-high. Reset forces state IDLE and all valid/ready outputs, out, counters and seed to 0, immediately, including mid-burst. No handshake resumes after reset.
- FSM: IDLE -> WR_AW -> WR_DATA -> WR_RESP -> (next burst: WR_AW | last: RD_AR) -> RD_DATA -> (next burst: RD_AR | last: DONE).
- Only one transaction outstanding; W is issued only after AW accepted.
- IDLE: wait for start. DONE: hold out; start re-enters WR_AW, clears fail and count.
- Every valid, once asserted, is held with its payload stable until ready. No combinational path from any ready input to any valid output.
- awlen/arlen = BURST_LEN-1; size = log2(DATA_W/8); burst = INCR (2'b01); wstrb all ones.
- Burst b address = BASE_ADDR + b*BURST_LEN*DATA_W/8.
- Beat pattern for global beat index k (0..NUM_BURSTS*BURST_LEN-1): 32-bit lane i = {(k+seed)[27:0], i[3:0]}; seed = 0 unless looping.
- wlast is asserted on beat BURST_LEN-1 only.
- bready = 1 only in WR_RESP; rready = 1 only in RD_DATA.
- Sticky fail is set on any of:
  - bresp != OKAY;
  - rresp != OKAY;
  - rdata != expected;
  - rlast on a beat other than BURST_LEN-1;
  - missing rlast on the final beat.
- After a fail the pass continues to DONE.
- Beat count increments on each accepted R beat and saturates at all ones.
- done = 1 only in DONE state.
- start in any state other than IDLE/DONE is ignored.

Optional Feature:
- Macro NOC_GEN_LOOP_EN.
  - Defined: on entering DONE, done pulses for one cycle, seed increments by 1 and the FSM re-enters WR_AW automatically. fail stays sticky across passes; the count keeps accumulating.
  - Undefined: seed is fixed at 0 and the FSM stays in DONE until start or rst.

Test Plan:
- Zero-wait memory slave, defaults, start pulse:
  - 16 AW/W/B sequences (64 W beats), then 16 AR/R sequences;
  - out = {1,0,30'd64}; first AW at 0x0, second AW at 0x40, awlen 3, awsize 4.
- Slave with random ready/valid gaps (0-5 cycles) on all channels -> same final out; awaddr/wdata/araddr stable while valid and not ready.
- Slave corrupts rdata beat 10 -> fail = 1, done = 1, count = 64; no early stop.
- Slave returns bresp = SLVERR on burst 3 -> fail = 1. Slave returns rlast on beat 1 of a burst -> fail = 1.
- Assert rst while wvalid = 1 mid-burst:
  - all valids 0 and out = 0 in the same cycle;
  - a new start afterwards completes with out = {1,0,30'd64}.
- start pulsed during RD_DATA -> ignored. With NOC_GEN_LOOP_EN:
  - the second pass writes lane 0 of beat 0 = 0x00000010;
  - done pulses once per pass.
